inst_fetch_bridge: RTL and testbench
====================================

# inst_fetch_bridge

Responder for the core's instruction-fetch port (`rom_ce`/`rom_addr` out, `rom_data` in). It serves 32-bit instruction words from a byte-wide synchronous RAM, assembling four little-endian bytes per word. It holds the last fetched word in a one-entry buffer. It raises a stall request to the `ctrl` block until the requested word is available. It sits between the core top level and the external memory port.

## Interface
- No parameters; widths come from `defines.v` (`InstAddrBus`/`InstBus` = 32, `MemBus` = 8).
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `rom_ce_i`  in  1  — fetch enable from `pc_reg`.
- `rom_addr_i`  in  32  — fetch byte address; bits [1:0] ignored.
- `rom_data_o`  out  32  — instruction word; valid when `rom_ce_i`=1 and `stallreq_o`=0, else 0.
- `stallreq_o`  out  1  — ORed into `ctrl` alongside `stallreq_from_id`/`stallreq_from_ex`.
- `mem_a_o`  out  32  — byte address to RAM.
- `mem_re_o`  out  1  — read request this cycle.
- `mem_busy_i`  in  1  — RAM refuses the request presented this cycle.
- `mem_din_i`  in  8  — read data; valid the cycle after an accepted request.

## Operation
- **Lookup (combinational).**
  - `hit = rom_ce_i & buf_valid & (buf_tag == rom_addr_i[31:2])`.
  - `stallreq_o = rom_ce_i & ~hit`.
  - `rom_data_o = hit ? buf_word : 0`.
- **FSM states:** IDLE, FETCH, FILL.
- **IDLE**
  - A miss latches `base = {rom_addr_i[31:2], 2'b00}`, clears issue count `icnt` and capture count `ccnt`, and goes to FETCH.
- **FETCH**
  - Drives `mem_re_o=1` and `mem_a_o = base + icnt`.
  - Request accepted when `mem_busy_i`=0. Acceptance sets `icnt++` and `pend=1` for next cycle. A refused request holds the same address.
  - When `icnt` reaches 4 (all bytes accepted), go to FILL.
- **Capture (FETCH and FILL)**
  - When `pend`=1, `mem_din_i` is written to staging byte `ccnt`, then `ccnt++`.
  - Byte k lands in bits [8k+7:8k].
- **FILL**
  - `mem_re_o=0`.
  - Once byte 3 is captured: `buf_word` ← staging, `buf_tag` ← `base[31:2]`, `buf_valid`=1, return to IDLE. The hit appears the next cycle.
- **Abort**
  - Triggered in FETCH/FILL by `rom_ce_i`=0 or `rom_addr_i[31:2] != base[31:2]` (branch redirect).
  - Return to IDLE at the next edge and discard staging and pending bytes.
  - `buf_*` is untouched; the old word stays valid.
- **Address arithmetic:** 32-bit, wraps at 0xFFFF_FFFF (base 0xFFFF_FFFC reads FC..FF).
- **Reset values:**
  - State IDLE, `buf_valid`=0, `buf_tag`=0, `buf_word`=0, `icnt`=`ccnt`=0, `pend`=0.
  - `mem_a_o`=0, `mem_re_o`=0.
  - `stallreq_o` and `rom_data_o` are 0 while `rst`=0.
- **Reset mid-fetch:** all of the above apply immediately (asynchronous). A RAM byte arriving after reset release is ignored because `pend`=0.

## Timing
- **Hit:** zero-cycle. Word and `stallreq_o`=0 in the same cycle as the address.
- **Miss, no busy:**
  - Cycle 0: miss seen, stall.
  - Cycles 1–4: request bytes 0–3.
  - Cycles 2–5: capture.
  - Cycle 6: hit.
  - `stallreq_o` is high for exactly 6 cycles.
- **Busy:** each cycle with `mem_busy_i`=1 during FETCH adds one cycle to the miss.
- **Abort:** abort seen in cycle t → IDLE in t+1. The new address starts its miss in t+1 (stall continues without a gap).
- **Registered outputs:** `mem_a_o` and `mem_re_o` are registered (from state and `icnt`). The lookup path is combinational.

## Structure
- Add to `defines.v`:
  - `MemBus` (7:0).
  - FSM encodings `FetchIdle`/`FetchFetch`/`FetchFill` (2 bits).
  - `FetchBytes` = 4.
- **Sub-module:** none required. The FSM, staging register and one-entry buffer live in one module.
- **Top-level wiring:** instantiated alongside the core. Core `rom_*` connects to this block, and `stallreq_o` feeds `ctrl`.

## Test plan
- **Reset then cold fetch:**
  - Stimulus: `rst` low 3 cycles; RAM 0x0..0x3 = 13,05,00,00; `rom_addr_i`=0, ce=1.
  - Required: stall 6 cycles, then `rom_data_o`=0x0000_0513.
  - Required: `mem_a_o` sequence 0,1,2,3 on cycles 1–4.
- **Repeat hit:** same address held → `rom_data_o`=0x0000_0513, `stallreq_o`=0, `mem_re_o`=0.
- **Busy stall:**
  - Stimulus: fetch 0x4 with `mem_busy_i` high on cycles 2–3.
  - Required: address 0x5 presented three cycles, stall lasts 8 cycles, word correct.
- **Redirect abort:**
  - Stimulus: fetch 0x8, switch `rom_addr_i` to 0x40 in cycle 3.
  - Required: fetch restarts at 0x40; buffer still holds 0x0 data until 0x40 completes; 0x40 word correct.
- **ce drop and unaligned address:**
  - Stimulus: ce low mid-fetch, then ce high with `rom_addr_i`=0x2.
  - Required: `rom_data_o`=0 while ce is low.
  - Required: `rom_addr_i`=0x2 returns word at 0x0 as a hit (bits [1:0] ignored, word already buffered).
- **Wrap and async reset:**
  - Stimulus: fetch 0xFFFF_FFFC.
  - Required: `mem_a_o` = FC,FD,FE,FF.
  - Stimulus: assert `rst` in cycle 3 of this fetch.
  - Required: outputs 0 immediately, `buf_valid`=0, next fetch is a full miss.

Source files
------------

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared types and constants for the instruction-fetch bridge.
// Byte-lane width, fetch FSM encoding and word-alignment helper.
package inst_fetch_bridge_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int MemBus      = 8;
  localparam int FetchBytes  = 4;

  typedef enum logic [1:0] {
    FetchIdle  = 2'd0,
    FetchFetch = 2'd1,
    FetchFill  = 2'd2
  } fetch_state_e;

  function automatic logic [InstAddrBus-1:0] word_base(
    input logic [InstAddrBus-1:0] a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// Byte-wide synchronous RAM port seen by the fetch bridge.
// master = bridge (issues requests), slave = RAM.
interface inst_fetch_bridge_if;
  import inst_fetch_bridge_pkg::*;

  logic [InstAddrBus-1:0] mem_a_o;
  logic                   mem_re_o;
  logic                   mem_busy_i;
  logic [MemBus-1:0]      mem_din_i;

  modport master (
    output mem_a_o,
    output mem_re_o,
    input  mem_busy_i,
    input  mem_din_i
  );

  modport slave (
    input  mem_a_o,
    input  mem_re_o,
    output mem_busy_i,
    output mem_din_i
  );

endinterface

// File: rtl/inst_fetch_bridge.sv
// Serves 32-bit fetch words from a byte-wide RAM through a
// one-entry word buffer; stalls the core until the word is held.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [InstAddrBus-1:0] rom_addr_i,
  output logic [InstBus-1:0]     rom_data_o,
  output logic                   stallreq_o,
  inst_fetch_bridge_if.master    mem
);

  fetch_state_e state;

  logic                   buf_valid;
  logic [29:0]            buf_tag;
  logic [InstBus-1:0]     buf_word;
  logic [InstBus-1:0]     staging;
  logic [InstBus-1:0]     cap_word;
  logic [InstAddrBus-1:0] base;
  logic [2:0]             icnt;
  logic [2:0]             icnt_nx;
  logic [1:0]             ccnt;
  logic                   pend;

  logic hit;
  logic abort;
  logic accept;
  logic last_cap;

  assign hit = rom_ce_i & buf_valid
             & (buf_tag == rom_addr_i[31:2]);

  assign stallreq_o = rst & rom_ce_i & ~hit;
  assign rom_data_o = hit ? buf_word : '0;

  assign abort = ~rom_ce_i
               | (rom_addr_i[31:2] != base[31:2]);

  assign accept = (state == FetchFetch)
                & ~mem.mem_busy_i;

  assign icnt_nx = icnt + 3'd1;

  assign last_cap = (state == FetchFill)
                  & pend & (ccnt == 2'd3);

  // Staging word with the incoming byte merged into lane ccnt.
  always_comb begin
    cap_word = staging;
    cap_word[{ccnt, 3'b000} +: MemBus] = mem.mem_din_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FetchIdle;
      buf_valid    <= 1'b0;
      buf_tag      <= '0;
      buf_word     <= '0;
      staging      <= '0;
      base         <= '0;
      icnt         <= '0;
      ccnt         <= '0;
      pend         <= 1'b0;
      mem.mem_a_o  <= '0;
      mem.mem_re_o <= 1'b0;
    end else begin
      unique case (state)
        FetchIdle: begin
          pend <= 1'b0;
          if (rom_ce_i && !hit) begin
            state        <= FetchFetch;
            base         <= word_base(rom_addr_i);
            icnt         <= '0;
            ccnt         <= '0;
            staging      <= '0;
            mem.mem_a_o  <= word_base(rom_addr_i);
            mem.mem_re_o <= 1'b1;
          end
        end
        FetchFetch, FetchFill: begin
          if (abort) begin
            // Buffer keeps its old word; partial data is dropped.
            state        <= FetchIdle;
            pend         <= 1'b0;
            icnt         <= '0;
            ccnt         <= '0;
            staging      <= '0;
            mem.mem_re_o <= 1'b0;
          end else begin
            pend <= accept;
            if (pend) begin
              staging <= cap_word;
              ccnt    <= ccnt + 2'd1;
            end
            if (accept) begin
              icnt <= icnt_nx;
              if (icnt_nx == 3'(FetchBytes)) begin
                state        <= FetchFill;
                mem.mem_re_o <= 1'b0;
              end else begin
                mem.mem_a_o <= base + {29'd0, icnt_nx};
              end
            end
            if (last_cap) begin
              buf_word  <= cap_word;
              buf_tag   <= base[31:2];
              buf_valid <= 1'b1;
              state     <= FetchIdle;
            end
          end
        end
        default: begin
          state        <= FetchIdle;
          pend         <= 1'b0;
          mem.mem_re_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge with a byte-RAM model
// and a word scoreboard checked when the stall drops.
module tb_inst_fetch_bridge;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        stall;
  logic        busy;

  int tests;
  int fails;

  logic [31:0] exp_q[$];

  inst_fetch_bridge_if mif();

  assign mif.mem_busy_i = busy;

  inst_fetch_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (ce),
    .rom_addr_i (addr),
    .rom_data_o (rdata),
    .stallreq_o (stall),
    .mem        (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'h00;
      32'h3:   return 8'h00;
      default: return a[7:0] * 8'd7 + 8'h31;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'd3;
    return {ram_rd(b + 32'd3), ram_rd(b + 32'd2),
            ram_rd(b + 32'd1), ram_rd(b)};
  endfunction

  // Synchronous RAM: data valid the cycle after an accepted request.
  always @(posedge clk) begin
    if (mif.mem_re_o && !busy)
      mif.mem_din_i <= ram_rd(mif.mem_a_o);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a,
                          input logic [15:0] bmask,
                          input int exp_stall,
                          input int exp_re,
                          input string tag);
    logic [31:0] acc[$];
    logic [31:0] b;
    int n;
    int re_n;
    bit done;
    n = 0;
    re_n = 0;
    done = 0;
    b = a & ~32'd3;
    exp_q.push_back(word_at(a));
    ce = 1'b1;
    addr = a;
    for (int c = 0; c < 40 && !done; c++) begin
      busy = (c < 16) && bmask[c[3:0]];
      @(negedge clk);
      if (mif.mem_re_o) re_n++;
      if (mif.mem_re_o && !busy) acc.push_back(mif.mem_a_o);
      if (!stall) done = 1;
      else begin
        n++;
        step();
      end
    end
    busy = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall"}, n, exp_stall);
    chk({tag, "_data"}, rdata, exp_q.pop_front());
    chk({tag, "_re"}, re_n, exp_re);
    if (exp_stall > 0) begin
      chk({tag, "_nacc"}, 32'(acc.size() >= 4), 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (acc.size() >= 4)
          chk({tag, "_addr"}, acc[acc.size() - 4 + k],
              b + 32'(k));
      end
    end
    step();
  endtask

  task automatic miss_cycles(input int k, input string tag);
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      chk({tag, "_stl"}, 32'(stall), 32'd1);
      chk({tag, "_dat"}, rdata, 32'd0);
      step();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    ce = 1'b1;
    addr = 32'h0;
    busy = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_re", 32'(mif.mem_re_o), 32'd0);
    chk("rst_a", mif.mem_a_o, 32'd0);
    step();
    rst = 1'b1;

    do_fetch(32'h0, 16'h0, 6, 4, "cold");
    do_fetch(32'h0, 16'h0, 0, 0, "hit");
    do_fetch(32'h4, 16'h000C, 8, 6, "busy");

    addr = 32'h8;
    miss_cycles(3, "redir_pre");
    do_fetch(32'h40, 16'h0, 7, 5, "redir");

    do_fetch(32'h0, 16'h0, 6, 4, "refill");
    addr = 32'h10;
    miss_cycles(3, "cedrop_pre");
    ce = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("cedrop_stall", 32'(stall), 32'd0);
      chk("cedrop_data", rdata, 32'd0);
      step();
    end
    do_fetch(32'h2, 16'h0, 0, 0, "unal");

    do_fetch(32'hFFFF_FFFC, 16'h0, 6, 4, "wrap");

    addr = 32'h20;
    miss_cycles(3, "arst_pre");
    rst = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_data", rdata, 32'd0);
    chk("arst_re", 32'(mif.mem_re_o), 32'd0);
    chk("arst_a", mif.mem_a_o, 32'd0);
    step();
    step();
    rst = 1'b1;
    do_fetch(32'hFFFF_FFFC, 16'h0, 6, 4, "post_rst");
    do_fetch(32'hFFFF_FFFC, 16'h0, 0, 0, "post_hit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
